// File: rtl/forward_converter_9_8_7_if.sv
// Handshake/result bundle for the {9,8,7} residue forward converter.
//   in_data   [8:0]  unsigned operand X
//   in_valid         X present on in_data
//   in_ready         converter accepts X this cycle
//   x1        [3:0]  X mod 9
//   x2        [2:0]  X mod 8
//   x3        [2:0]  X mod 7
//   out_err          X was above the dynamic range (X > 503)
//   out_valid        x1/x2/x3/out_err hold a valid result
//   out_ready        downstream consumes the result this cycle
// The converter itself connects through the slave modport; the producer /
// consumer side uses master.
interface forward_converter_9_8_7_if;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x1;
    logic [2:0] x2;
    logic [2:0] x3;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, x1, x2, x3, out_err, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, x1, x2, x3, out_err, out_valid
    );
endinterface

// File: rtl/forward_converter_9_8_7.sv
// Binary to residue-number-system forward converter for moduli {9,8,7}
// (dynamic range 504). Two-stage valid/ready pipeline, latency 2, one
// result per cycle when downstream is ready.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; drops all in-flight operands
//   bus   slave side of forward_converter_9_8_7_if (see interface header)
// X is split as 64*a + 8*b + c. Since 64 = 1 and 8 = 1 (mod 7), X mod 7 is
// (a+b+c) mod 7; since 64 = 1 and 8 = -1 (mod 9), X mod 9 is (a-b+c) mod 9,
// which is biased by +9 so the stage-1 sum never goes negative.
module forward_converter_9_8_7 (
    input  logic                      clk,
    input  logic                      rst,
    forward_converter_9_8_7_if.slave  bus
);

    // Reduce a 0..21 sum modulo 7 by compare-and-subtract.
    function automatic logic [2:0] reduce_mod7(input logic [4:0] s);
        logic [2:0] r;
        if (s >= 5'd21) begin
            r = 3'(s - 5'd21);
        end else if (s >= 5'd14) begin
            r = 3'(s - 5'd14);
        end else if (s >= 5'd7) begin
            r = 3'(s - 5'd7);
        end else begin
            r = 3'(s);
        end
        return r;
    endfunction

    // Reduce a 2..23 sum modulo 9 by compare-and-subtract.
    function automatic logic [3:0] reduce_mod9(input logic [4:0] s);
        logic [3:0] r;
        if (s >= 5'd18) begin
            r = 4'(s - 5'd18);
        end else if (s >= 5'd9) begin
            r = 4'(s - 5'd9);
        end else begin
            r = 4'(s);
        end
        return r;
    endfunction

    logic [2:0] a_s;
    logic [2:0] b_s;
    logic [2:0] c_s;
    logic [4:0] s7_s;
    logic [4:0] s9_s;
    logic       err_s;
    logic       adv1_s;
    logic       adv2_s;

    logic       v1_r;
    logic [4:0] s7_r;
    logic [4:0] s9_r;
    logic [2:0] c_r;
    logic       err_r;

    logic       v2_r;
    logic [3:0] x1_r;
    logic [2:0] x2_r;
    logic [2:0] x3_r;
    logic       out_err_r;

    // Digit split and first-stage partial sums of the incoming operand.
    always_comb begin
        a_s   = bus.in_data[8:6];
        b_s   = bus.in_data[5:3];
        c_s   = bus.in_data[2:0];
        s7_s  = {2'b00, a_s} + {2'b00, b_s} + {2'b00, c_s};
        s9_s  = {2'b00, a_s} + {2'b00, c_s} + 5'd9 - {2'b00, b_s};
        err_s = (bus.in_data > 9'd503);
    end

    // Pipeline advance conditions; in_ready depends only on state and out_ready.
    always_comb begin
        adv2_s = ~v2_r | bus.out_ready;
        adv1_s = ~v1_r | adv2_s;
    end

    // Stage-1 valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r <= 1'b0;
        end else if (adv1_s) begin
            v1_r <= bus.in_valid;
        end else begin
            v1_r <= v1_r;
        end
    end

    // Stage-1 datapath; not reset, only meaningful while v1_r is set.
    always_ff @(posedge clk) begin
        if (adv1_s && bus.in_valid) begin
            s7_r  <= s7_s;
            s9_r  <= s9_s;
            c_r   <= c_s;
            err_r <= err_s;
        end else begin
            s7_r  <= s7_r;
            s9_r  <= s9_r;
            c_r   <= c_r;
            err_r <= err_r;
        end
    end

    // Stage-2 valid bit; it is out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r <= 1'b0;
        end else if (adv2_s) begin
            v2_r <= v1_r;
        end else begin
            v2_r <= v2_r;
        end
    end

    // Stage-2 result registers; loaded only with real data so they hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_r      <= 4'd0;
            x2_r      <= 3'd0;
            x3_r      <= 3'd0;
            out_err_r <= 1'b0;
        end else if (adv2_s && v1_r) begin
            x1_r      <= reduce_mod9(s9_r);
            x2_r      <= c_r;
            x3_r      <= reduce_mod7(s7_r);
            out_err_r <= err_r;
        end else begin
            x1_r      <= x1_r;
            x2_r      <= x2_r;
            x3_r      <= x3_r;
            out_err_r <= out_err_r;
        end
    end

    assign bus.in_ready  = adv1_s;
    assign bus.out_valid = v2_r;
    assign bus.x1        = x1_r;
    assign bus.x2        = x2_r;
    assign bus.x3        = x3_r;
    assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_forward_converter_9_8_7.sv
// Self-checking bench for forward_converter_9_8_7. The reference model is a
// queue of accepted operands with the edge at which each may first appear on
// the output; residues come from plain % arithmetic and a CRT round trip.
module tb_forward_converter_9_8_7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    forward_converter_9_8_7_if bus_if();

    forward_converter_9_8_7 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int x;
        int arrive;
    } item_t;

    item_t q[$];
    int    edge_n   = 0;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_out    = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check at the falling edge, update the model, cross the rising edge.
    task automatic step();
        int    exp_valid;
        int    exp_ready;
        int    rt;
        bit    acc;
        bit    xfer;
        item_t it;
        @(negedge clk);
        exp_valid = (q.size() > 0 && q[0].arrive <= edge_n) ? 1 : 0;
        exp_ready = (q.size() >= 2 && !bus_if.out_ready) ? 0 : 1;
        check_val("out_valid", int'(bus_if.out_valid), exp_valid);
        check_val("in_ready", int'(bus_if.in_ready), exp_ready);
        if (exp_valid == 1 && bus_if.out_valid) begin
            check_val("x1", int'(bus_if.x1), q[0].x % 9);
            check_val("x2", int'(bus_if.x2), q[0].x % 8);
            check_val("x3", int'(bus_if.x3), q[0].x % 7);
            check_val("out_err", int'(bus_if.out_err), (q[0].x > 503) ? 1 : 0);
            if (q[0].x < 504) begin
                rt = (int'(bus_if.x1) * 280 + int'(bus_if.x2) * 441 + int'(bus_if.x3) * 288) % 504;
                check_val("roundtrip", rt, q[0].x);
            end
        end
        acc  = bus_if.in_valid && bus_if.in_ready;
        xfer = bus_if.out_valid && bus_if.out_ready;
        if (xfer) begin
            n_out++;
            if (q.size() > 0) begin
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].arrive < edge_n + 1) begin
                q[0].arrive = edge_n + 1;
            end
        end
        if (acc) begin
            it.x      = int'(bus_if.in_data);
            it.arrive = edge_n + 2;
            q.push_back(it);
        end
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    // Single operand with out_ready high; residues against literal values.
    task automatic directed(input int x, input int e1, input int e2, input int e3, input int ee);
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 9'(x);
        bus_if.out_ready = 1'b1;
        step();
        bus_if.in_valid = 1'b0;
        step();
        check_val($sformatf("dir%0d_valid", x), int'(bus_if.out_valid), 1);
        check_val($sformatf("dir%0d_x1", x), int'(bus_if.x1), e1);
        check_val($sformatf("dir%0d_x2", x), int'(bus_if.x2), e2);
        check_val($sformatf("dir%0d_x3", x), int'(bus_if.x3), e3);
        check_val($sformatf("dir%0d_err", x), int'(bus_if.out_err), ee);
        step();
    endtask

    task automatic drain(input string tag);
        int budget;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            step();
            budget++;
        end
        check_val(tag, q.size(), 0);
    endtask

    initial begin
        int start_out;
        int budget;

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 9'd0;
        bus_if.out_ready = 1'b0;
        #1;
        check_val("rst_out_valid", int'(bus_if.out_valid), 0);
        check_val("rst_in_ready", int'(bus_if.in_ready), 1);
        check_val("rst_x1", int'(bus_if.x1), 0);
        check_val("rst_x2", int'(bus_if.x2), 0);
        check_val("rst_x3", int'(bus_if.x3), 0);
        check_val("rst_err", int'(bus_if.out_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        directed(0,   0, 0, 0, 0);
        directed(100, 1, 4, 2, 0);
        directed(503, 8, 7, 6, 0);
        directed(504, 0, 0, 0, 1);
        directed(511, 7, 7, 0, 1);

        // Full operand sweep back-to-back.
        start_out = n_out;
        for (int i = 0; i < 512; i++) begin
            bus_if.in_valid  = 1'b1;
            bus_if.in_data   = 9'(i);
            bus_if.out_ready = 1'b1;
            step();
        end
        drain("stream_drain");
        check_val("stream_count", n_out - start_out, 512);

        // Random valid / ready traffic.
        for (int i = 0; i < 2000; i++) begin
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.in_data   = 9'($urandom_range(0, 511));
            bus_if.out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            step();
        end
        drain("random_drain");

        // Fill both stages, then reset with two operands in flight.
        bus_if.out_ready = 1'b0;
        budget = 0;
        while (q.size() < 2 && budget < 10) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = 9'($urandom_range(0, 503));
            step();
            budget++;
        end
        check_val("fill_two", q.size(), 2);
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", int'(bus_if.out_valid), 0);
        check_val("midrst_in_ready", int'(bus_if.in_ready), 1);
        check_val("midrst_x1", int'(bus_if.x1), 0);
        check_val("midrst_err", int'(bus_if.out_err), 0);
        q.delete();
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Post-reset random traffic; the first output must be the first new operand.
        for (int i = 0; i < 600; i++) begin
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.in_data   = 9'($urandom_range(0, 511));
            bus_if.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
